mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
Scan sequencer that sits directly upstream of the 16:1 byte mux. It drives the mux select through the channels enabled in a mask and samples the selected byte. Each captured byte goes out on a valid/ready stream tagged with its channel index and a last flag. It turns the combinational mux into a frame-based byte source for the downstream serializer and UART stages.

Parameters:
N_CH, 16, number of mux channels (fixed at 16 for this revision)
SEL_W, 4, select width, log2(N_CH)
DATA_W, 8, byte width of mux data

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin one scan frame
ch_mask  input  N_CH  channel enable mask; bit i set means channel i is scanned
mux_sel  output  SEL_W  select driven to the mux
mux_data  input  DATA_W  mux output; combinational function of mux_sel
out_valid  output  1  output byte valid
out_ready  input  1  downstream accepts the byte
out_data  output  DATA_W  captured byte
out_ch  output  SEL_W  channel index of out_data
out_last  output  1  out_data is the final enabled channel of the frame
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset values (reset asserted, async): state IDLE, idx=0, mask_q=0, mux_sel=0, out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0, done=0.
- mux_sel equals idx in every state (registered, not decoded). mux_data is sampled in the same cycle as mux_sel, with no settle cycle.
- States:
  - IDLE
    - busy=0.
    - start=1 with ch_mask!=0: mask_q<=ch_mask, idx<=0, go FIND.
    - start=1 with ch_mask==0: done=1 the next cycle, stay IDLE.
  - FIND
    - busy=1, one channel examined per cycle.
    - mask_q[idx]=1: out_data<=mux_data, out_ch<=idx, out_last<=(mask_q has no set bit above idx), out_valid<=1, go SEND.
    - Otherwise: idx<=idx+1.
  - SEND
    - busy=1. out_valid, out_data, out_ch and out_last are held stable until the handshake.
    - On out_valid&&out_ready with out_last=1: out_valid<=0, done=1 the next cycle, idx<=0, go IDLE.
    - On out_valid&&out_ready with out_last=0: out_valid<=0, idx<=idx+1, go FIND.
- Latency:
  - start sampled at edge E0 with lowest set bit k: out_valid rises after edge E(k+1).
  - Handshake at edge H on channel i, next enabled channel j: out_valid rises after edge H+(j-i).
  - Minimum one idle (out_valid=0) cycle between beats.
- done: exactly one cycle, in the cycle after the last handshake edge; busy is already 0 in that cycle.
- Boundaries:
  - start while busy is ignored.
  - ch_mask changes mid-frame are ignored; mask_q is latched at start.
  - idx never wraps within a frame, because out_last terminates at the highest set bit.
  - A mask with only bit 15 set scans 16 FIND cycles.
  - out_ready may be held high permanently, or may stall arbitrarily long in SEND.
  - out_ready while out_valid=0 has no effect.
- Reset mid-frame: everything returns to reset values immediately, with no done pulse. The partial frame is dropped and the next start begins a fresh frame.

Test Plan:
- Bench mux model: data_i = 8'h10+i. mask 16'h0001, out_ready=1, start at E0 -> out_valid after E1, out_data=8'h10, out_ch=0, out_last=1, then done pulse one cycle after the handshake, busy 0.
- mask 16'h8001, out_ready=1 -> beats (8'h10, ch 0, last 0) then (8'h1F, ch 15, last 1); second out_valid rises 15 edges after the first handshake; exactly one done.
- mask 16'h0000, start -> no out_valid, done=1 one cycle later, busy stays 0.
- mask 16'h0024, out_ready=0 for 5 cycles on the first beat -> out_data=8'h12 and out_ch=2 held stable all 5 cycles; after ready, beat 8'h15/ch 5/last 1.
- mask 16'h00F0; pulse start again mid-frame and change ch_mask to 16'hFFFF -> exactly 4 beats (ch 4..7), one done.
- mask 16'hFFFF; assert reset during the third SEND -> out_valid, busy and mux_sel go to 0 asynchronously, no done. Fresh start after release -> beats again from ch 0.

Source files
------------

// File: rtl/mux_scan_seq.sv
// Scan sequencer: steps the 16:1 mux select through the enabled channels and streams each sampled byte.
// Latency: first beat valid k+1 edges after start (k = lowest enabled channel); next beat j-i edges after a handshake.
// Backpressure: a beat is held stable in SEND until out_ready; scanning pauses for the whole stall.
module mux_scan_seq #(
  parameter int N_CH   = 16,
  parameter int SEL_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FIND, S_SEND} state_t;

  localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);

  state_t              r_state, w_state_nx;
  logic [SEL_W-1:0]    r_idx, w_idx_nx;
  logic [N_CH-1:0]     r_mask, w_mask_nx;
  logic                r_valid, w_valid_nx;
  logic [DATA_W-1:0]   r_data, w_data_nx;
  logic [SEL_W-1:0]    r_ch, w_ch_nx;
  logic                r_last, w_last_nx;
  logic                r_done, w_done_nx;

  // Bits of the latched mask at and above the current index; the channel is
  // the last of the frame when nothing above it remains set.
  logic [N_CH-1:0]     w_hi_bits;
  logic                w_is_last;

  assign w_hi_bits = r_mask >> r_idx;
  assign w_is_last = (w_hi_bits[N_CH-1:1] == '0);

  // Select is the registered index itself so the mux sees a glitch-free value.
  assign mux_sel   = r_idx;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_last  = r_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  // Next-state and next-datapath decode; everything holds unless a state moves it.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_mask_nx  = r_mask;
    w_valid_nx = r_valid;
    w_data_nx  = r_data;
    w_ch_nx    = r_ch;
    w_last_nx  = r_last;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (ch_mask != '0) begin
            w_mask_nx  = ch_mask;
            w_idx_nx   = '0;
            w_state_nx = S_FIND;
          end else begin
            // Empty frame: complete immediately without touching the mux.
            w_done_nx = 1'b1;
          end
        end
      end
      S_FIND: begin
        if (r_mask[r_idx]) begin
          w_data_nx  = mux_data;
          w_ch_nx    = r_idx;
          w_last_nx  = w_is_last;
          w_valid_nx = 1'b1;
          w_state_nx = S_SEND;
        end else begin
          // A higher set bit always exists here, so the index cannot wrap.
          w_idx_nx = r_idx + IDX_ONE;
        end
      end
      S_SEND: begin
        if (r_valid && out_ready) begin
          w_valid_nx = 1'b0;
          if (r_last) begin
            w_done_nx  = 1'b1;
            w_idx_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_idx_nx   = r_idx + IDX_ONE;
            w_state_nx = S_FIND;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_idx_nx   = '0;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Datapath registers: index, latched mask, output beat and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_idx   <= w_idx_nx;
      r_mask  <= w_mask_nx;
      r_valid <= w_valid_nx;
      r_data  <= w_data_nx;
      r_ch    <= w_ch_nx;
      r_last  <= w_last_nx;
      r_done  <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: directed frames from the test plan followed by random frames.
// Expected beats come from the frame mask: ascending set bits, byte 0x10+ch, last on highest bit.
// Beat timing expected as j-prev edges, where prev is the previous beat's channel (-1 at start).
module tb_mux_scan_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] ch_mask;
  logic [3:0]  mux_sel;
  logic [7:0]  mux_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_ch;
  logic        out_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  mux_scan_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ch_mask   (ch_mask),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Mux model: channel i carries 0x10+i.
  assign mux_data = 8'h10 + {4'h0, mux_sel};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one frame. stall >= 0: fixed stall per beat; stall < 0: random 0..-stall.
  // abort_at >= 0: assert reset while that beat is in SEND.
  task automatic frame(input logic [15:0] m, input int stall, input bit keep_rdy,
                       input bit disturb, input int abort_at);
    int hi, prev, cnt, beat, s;
    hi = -1;
    for (int i = 0; i < 16; i++) if (m[i]) hi = i;
    ch_mask   = m;
    start     = 1'b1;
    out_ready = keep_rdy;
    tick();
    start = 1'b0;
    if (m == 16'h0000) begin
      chk("empty_busy", busy, 0);
      chk("empty_valid", out_valid, 0);
      chk("empty_done", done, 1);
      tick();
      chk("empty_done_end", done, 0);
      chk("empty_valid_end", out_valid, 0);
      return;
    end
    prev = -1;
    beat = 0;
    for (int j = 0; j < 16; j++) begin
      if (m[j]) begin
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
          chk("find_busy", busy, 1);
          chk("find_done", done, 0);
          if (disturb) begin
            start   = 1'($urandom_range(0, 1));
            ch_mask = 16'($urandom);
          end
          if (!keep_rdy) out_ready = 1'($urandom_range(0, 1));
          tick();
          cnt++;
        end
        start     = 1'b0;
        out_ready = keep_rdy;
        chk("latency", cnt, j - prev);
        chk("data", out_data, 8'h10 + j);
        chk("ch", out_ch, j);
        chk("last", out_last, (j == hi));
        chk("send_busy", busy, 1);
        if (beat == abort_at) begin
          reset = 1'b1;
          #1;
          chk("rst_valid", out_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_sel", mux_sel, 0);
          chk("rst_done", done, 0);
          tick();
          reset = 1'b0;
          tick();
          chk("rst_after_done", done, 0);
          chk("rst_after_valid", out_valid, 0);
          chk("rst_after_busy", busy, 0);
          return;
        end
        s = keep_rdy ? 0 : ((stall >= 0) ? stall : $urandom_range(0, -stall));
        for (int k = 0; k < s; k++) begin
          if (disturb) begin
            start   = 1'($urandom_range(0, 1));
            ch_mask = 16'($urandom);
          end
          tick();
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, 8'h10 + j);
          chk("hold_ch", out_ch, j);
          chk("hold_last", out_last, (j == hi));
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("idle_gap", out_valid, 0);
        if (j == hi) begin
          chk("done_pulse", done, 1);
          chk("done_busy", busy, 0);
          chk("done_sel", mux_sel, 0);
        end else begin
          chk("no_done", done, 0);
          chk("mid_busy", busy, 1);
          chk("next_sel", mux_sel, j + 1);
        end
        out_ready = keep_rdy;
        prev = j;
        beat++;
      end
    end
    tick();
    chk("end_done", done, 0);
    chk("end_busy", busy, 0);
    chk("end_valid", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rm;
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    ch_mask   = 16'h0000;
    #1 reset = 1'b1;
    #1;
    chk("rst_sel0", mux_sel, 0);
    chk("rst_valid0", out_valid, 0);
    chk("rst_data0", out_data, 0);
    chk("rst_ch0", out_ch, 0);
    chk("rst_last0", out_last, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    frame(16'h0001, 0, 1'b1, 1'b0, -1);
    frame(16'h8001, 0, 1'b1, 1'b0, -1);
    frame(16'h0000, 0, 1'b0, 1'b0, -1);
    frame(16'h0024, 5, 1'b0, 1'b0, -1);
    frame(16'h00F0, 2, 1'b0, 1'b1, -1);
    frame(16'h8000, 0, 1'b1, 1'b0, -1);
    frame(16'hFFFF, 0, 1'b1, 1'b0, 2);
    frame(16'hFFFF, 0, 1'b1, 1'b0, -1);

    repeat (40) begin
      rm = 16'($urandom) & 16'($urandom);
      frame(rm, -6, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    rm = 16'($urandom) | 16'h0100;
    frame(rm, -3, 1'b0, 1'b0, 0);
    frame(16'h0003, 1, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
